// File: rtl/rv32i_types.sv
// Shared RV32I type package: opcodes, load/store funct3 encodings, memory
// word/mask types, LSU state encoding, byte-enable constants and small
// helpers for store lane placement and alignment checks.
package rv32i_types;

  typedef logic [31:0] rv32i_word;
  typedef logic [3:0]  rv32i_mem_wmask;

  typedef enum logic [6:0] {
    op_lui   = 7'b0110111,
    op_auipc = 7'b0010111,
    op_jal   = 7'b1101111,
    op_jalr  = 7'b1100111,
    op_br    = 7'b1100011,
    op_load  = 7'b0000011,
    op_store = 7'b0100011,
    op_imm   = 7'b0010011,
    op_reg   = 7'b0110011,
    op_csr   = 7'b1110011
  } rv32i_opcode;

  typedef enum logic [2:0] {
    lb  = 3'b000,
    lh  = 3'b001,
    lw  = 3'b010,
    lbu = 3'b100,
    lhu = 3'b101
  } load_funct3_t;

  typedef enum logic [2:0] {
    sb = 3'b000,
    sh = 3'b001,
    sw = 3'b010
  } store_funct3_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } lsu_state_t;

  localparam rv32i_mem_wmask BE_BYTE = 4'b0001;
  localparam rv32i_mem_wmask BE_HALF = 4'b0011;
  localparam rv32i_mem_wmask BE_WORD = 4'b1111;

  function automatic logic load_f3_legal(input logic [2:0] f3);
    return (f3 == lb) || (f3 == lh) || (f3 == lw) || (f3 == lbu) || (f3 == lhu);
  endfunction

  function automatic logic store_f3_legal(input logic [2:0] f3);
    return !f3[2] && (f3[1:0] != 2'b11);
  endfunction

  // size: funct3[1:0] (00 byte, 01 half, 10 word)
  function automatic rv32i_mem_wmask store_wmask(input logic [1:0] size, input logic [1:0] off);
    case (size)
      2'b00:   return BE_BYTE << off;
      2'b01:   return BE_HALF << {off[1], 1'b0};
      default: return BE_WORD;
    endcase
  endfunction

  function automatic rv32i_word store_lanes(input logic [1:0] size, input logic [1:0] off,
                                            input rv32i_word wdata);
    case (size)
      2'b00:   return {24'b0, wdata[7:0]} << {off, 3'b000};
      2'b01:   return {16'b0, wdata[15:0]} << {off[1], 4'b0000};
      default: return wdata;
    endcase
  endfunction

  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] off);
    return ((size == 2'b01) && off[0]) || ((size == 2'b10) && (off != 2'b00));
  endfunction

endpackage

// File: rtl/lsu_load_align.sv
// Load result extraction: picks the byte/half/word addressed by the offset
// out of the returned memory word and sign- or zero-extends it.
// Ports: i_word (memory word), i_off (addr[1:0]), i_funct3 (load type), o_data (result).
module lsu_load_align
  import rv32i_types::*;
(
  input  logic [31:0] i_word,
  input  logic [1:0]  i_off,
  input  logic [2:0]  i_funct3,
  output logic [31:0] o_data
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  assign w_byte = i_word[{i_off, 3'b000} +: 8];
  // Halfword selection ignores off[0]: misaligned halves are truncated down.
  assign w_half = i_off[1] ? i_word[31:16] : i_word[15:0];

  always_comb begin
    o_data = '0;
    case (load_funct3_t'(i_funct3))
      lb:      o_data = {{24{w_byte[7]}}, w_byte};
      lbu:     o_data = {24'b0, w_byte};
      lh:      o_data = {{16{w_half[15]}}, w_half};
      lhu:     o_data = {16'b0, w_half};
      lw:      o_data = i_word;
      default: o_data = '0;
    endcase
  end

endmodule

// File: rtl/lsu_mem_ctrl.sv
// Load/store unit memory controller for the MEM stage. Accepts one request at
// a time (req_ready high only in IDLE), drives the word-aligned memory port
// with byte enables and lane-shifted store data, waits for mem_resp and
// returns a one-cycle resp_valid pulse with the extended load data.
// Ports: req_* request in; resp_* completion out; mem_* memory port.
// Parameter RESP_TIMEOUT: ACCESS cycles before giving up with resp_err (0 = never).
// Macro LSU_MISALIGN_TRAP_EN: misaligned lh/lhu/sh/lw/sw report resp_err with
// no memory access; when undefined, low address bits are silently truncated.
module lsu_mem_ctrl
  import rv32i_types::*;
#(
  parameter int unsigned RESP_TIMEOUT = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [6:0]  req_opcode,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic        mem_read,
  output logic        mem_write,
  output logic [31:0] mem_address,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_byte_enable,
  input  logic        mem_resp,
  input  logic [31:0] mem_rdata
);

  lsu_state_t     r_state;
  logic [2:0]     r_funct3;
  logic [1:0]     r_off;
  logic           r_is_load;
  logic [31:0]    r_tmo_cnt;
  logic           r_mem_read;
  logic           r_mem_write;
  rv32i_word      r_mem_address;
  rv32i_word      r_mem_wdata;
  rv32i_mem_wmask r_mem_be;
  logic           r_resp_valid;
  logic           r_resp_err;
  rv32i_word      r_resp_rdata;

  logic      w_is_load;
  logic      w_is_store;
  logic      w_f3_illegal;
  logic      w_misalign;
  logic      w_tmo_hit;
  rv32i_word w_load_data;

  assign w_is_load    = (req_opcode == op_load);
  assign w_is_store   = (req_opcode == op_store);
  assign w_f3_illegal = (w_is_load  && !load_f3_legal(req_funct3)) ||
                        (w_is_store && !store_f3_legal(req_funct3));

`ifdef LSU_MISALIGN_TRAP_EN
  assign w_misalign = (w_is_load || w_is_store) && is_misaligned(req_funct3[1:0], req_addr[1:0]);
`else
  assign w_misalign = 1'b0;
`endif

  // Terminal count is reached in the RESP_TIMEOUT-th ACCESS cycle; a mem_resp
  // arriving in that same cycle takes priority in the FSM below.
  assign w_tmo_hit = (RESP_TIMEOUT != 0) && (r_tmo_cnt == 32'(RESP_TIMEOUT - 1));

  lsu_load_align u_load_align (
    .i_word   (mem_rdata),
    .i_off    (r_off),
    .i_funct3 (r_funct3),
    .o_data   (w_load_data)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state       <= IDLE;
      r_funct3      <= '0;
      r_off         <= '0;
      r_is_load     <= 1'b0;
      r_tmo_cnt     <= '0;
      r_mem_read    <= 1'b0;
      r_mem_write   <= 1'b0;
      r_mem_address <= '0;
      r_mem_wdata   <= '0;
      r_mem_be      <= '0;
      r_resp_valid  <= 1'b0;
      r_resp_err    <= 1'b0;
      r_resp_rdata  <= '0;
    end else begin
      r_resp_valid <= 1'b0;
      case (r_state)
        IDLE: begin
          if (req_valid) begin
            r_funct3     <= req_funct3;
            r_off        <= req_addr[1:0];
            r_is_load    <= w_is_load;
            r_tmo_cnt    <= '0;
            r_resp_err   <= 1'b0;
            r_resp_rdata <= '0;
            if ((w_is_load || w_is_store) && !w_f3_illegal && !w_misalign) begin
              r_state       <= ACCESS;
              r_mem_read    <= w_is_load;
              r_mem_write   <= w_is_store;
              r_mem_address <= {req_addr[31:2], 2'b00};
              r_mem_be      <= w_is_store ? store_wmask(req_funct3[1:0], req_addr[1:0]) : BE_WORD;
              r_mem_wdata   <= w_is_store ? store_lanes(req_funct3[1:0], req_addr[1:0], req_wdata) : '0;
            end else begin
              // Non-memory opcodes complete cleanly; bad funct3 or alignment errors.
              r_state      <= RESP;
              r_resp_valid <= 1'b1;
              r_resp_err   <= w_is_load || w_is_store;
            end
          end
        end
        ACCESS: begin
          if (mem_resp) begin
            r_state      <= RESP;
            r_mem_read   <= 1'b0;
            r_mem_write  <= 1'b0;
            r_resp_valid <= 1'b1;
            r_resp_rdata <= r_is_load ? w_load_data : '0;
          end else if (w_tmo_hit) begin
            r_state      <= RESP;
            r_mem_read   <= 1'b0;
            r_mem_write  <= 1'b0;
            r_resp_valid <= 1'b1;
            r_resp_err   <= 1'b1;
          end else begin
            r_tmo_cnt <= r_tmo_cnt + 32'd1;
          end
        end
        RESP: begin
          r_state      <= IDLE;
          r_resp_err   <= 1'b0;
          r_resp_rdata <= '0;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign req_ready       = (r_state == IDLE);
  assign resp_valid      = r_resp_valid;
  assign resp_err        = r_resp_err;
  assign resp_rdata      = r_resp_rdata;
  assign mem_read        = r_mem_read;
  assign mem_write       = r_mem_write;
  assign mem_address     = r_mem_address;
  assign mem_wdata       = r_mem_wdata;
  assign mem_byte_enable = r_mem_be;

endmodule

// File: tb/tb_lsu_mem_ctrl.sv
// Scoreboard bench for lsu_mem_ctrl: a byte-array reference memory predicts
// every response and memory transaction at accept time; a memory responder
// and a response monitor pop and compare independently.
module tb_lsu_mem_ctrl;
  import rv32i_types::*;

  localparam int TMO = 8;
`ifdef LSU_MISALIGN_TRAP_EN
  localparam bit TRAP = 1'b1;
`else
  localparam bit TRAP = 1'b0;
`endif
  localparam logic [6:0] OP_LD = 7'b0000011;
  localparam logic [6:0] OP_ST = 7'b0100011;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic [6:0]  req_opcode;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic        mem_read;
  logic        mem_write;
  logic [31:0] mem_address;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_byte_enable;
  logic        mem_resp = 1'b0;
  logic [31:0] mem_rdata = '0;

  lsu_mem_ctrl #(.RESP_TIMEOUT(TMO)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_opcode(req_opcode),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
    .mem_read(mem_read), .mem_write(mem_write), .mem_address(mem_address),
    .mem_wdata(mem_wdata), .mem_byte_enable(mem_byte_enable),
    .mem_resp(mem_resp), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // kind: 0 = no access (due accept+1), 1 = memory completion (due mem_resp+1),
  // 2 = timeout (due accept+TMO+1)
  typedef struct { bit err; logic [31:0] rdata; int kind; int accept; } resp_t;
  typedef struct { bit we; logic [31:0] addr; logic [3:0] be; logic [31:0] wdata; int delay; } mtx_t;

  resp_t exp_q[$];
  mtx_t  mtx_q[$];
  logic [7:0] ref_mem[64];
  logic [7:0] phys_mem[64];
  int last_mresp = 0;
  int n_chk = 0;
  int n_pass = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: actual %h required %h (cycle %0d)", name, act, exp, cyc);
  endtask

  task automatic fail_now(input string name);
    n_chk++;
    $display("FAIL %s (cycle %0d)", name, cyc);
  endtask

  // Reference model: evaluated at the cycle the request is accepted.
  task automatic model_issue(input logic [6:0] op, input logic [2:0] f3, input logic [31:0] addr,
                             input logic [31:0] wd, input int delay, input int acc);
    resp_t e;
    mtx_t m;
    int size, bo;
    bit is_ld, is_st, legal, mis;
    logic [31:0] base;
    longint v;
    is_ld = (op == OP_LD);
    is_st = (op == OP_ST);
    e.accept = acc; e.err = 1'b0; e.rdata = '0; e.kind = 0;
    if (!is_ld && !is_st) begin exp_q.push_back(e); return; end
    legal = is_ld ? (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5}) : (f3 < 3'd3);
    size  = 1 << f3[1:0];
    mis   = legal && ((addr % size) != 0);
    if (!legal || (TRAP && mis)) begin e.err = 1'b1; exp_q.push_back(e); return; end
    base = addr & ~(size - 1);
    bo = int'(base % 4);
    m.we = is_st; m.addr = base & ~32'd3; m.delay = delay; m.be = 4'b1111; m.wdata = '0;
    if (is_st) begin
      m.be = 4'b0000;
      for (int i = 0; i < size; i++) begin
        m.be[bo + i] = 1'b1;
        m.wdata[8*(bo + i) +: 8] = wd[8*i +: 8];
      end
    end
    mtx_q.push_back(m);
    if (delay < 0) begin
      e.err = 1'b1; e.kind = 2;
    end else begin
      e.kind = 1;
      if (is_st) begin
        for (int i = 0; i < size; i++) ref_mem[(base + i) % 64] = wd[8*i +: 8];
      end else begin
        v = 0;
        for (int i = 0; i < size; i++) v = v + (longint'(ref_mem[(base + i) % 64]) << (8*i));
        if (!f3[2] && size < 4 && ((v >> (8*size - 1)) & 1) == 1) v = v - (longint'(1) << (8*size));
        e.rdata = v[31:0];
      end
    end
    exp_q.push_back(e);
  endtask

  task automatic issue(input logic [6:0] op, input logic [2:0] f3, input logic [31:0] addr,
                       input logic [31:0] wd, input int delay);
    int n = 0;
    @(negedge clk);
    req_valid = 1'b1; req_opcode = op; req_funct3 = f3; req_addr = addr; req_wdata = wd;
    while (!req_ready && n < 200) begin @(negedge clk); n++; end
    if (!req_ready) begin fail_now("req_ready_wait_expired"); req_valid = 1'b0; return; end
    model_issue(op, f3, addr, wd, delay, cyc);
    @(posedge clk);
    #1;
    req_valid = 1'b0; req_opcode = 7'($urandom); req_addr = $urandom; req_wdata = $urandom;
  endtask

  task automatic drain();
    int n = 0;
    while ((exp_q.size() != 0 || mtx_q.size() != 0) && n < 200) begin @(negedge clk); n++; end
    if (exp_q.size() != 0 || mtx_q.size() != 0) fail_now("drain_expired");
    @(negedge clk);
  endtask

  task automatic poke_word(input logic [31:0] addr, input logic [31:0] w);
    for (int i = 0; i < 4; i++) begin
      ref_mem[(addr + i) % 64]  = w[8*i +: 8];
      phys_mem[(addr + i) % 64] = w[8*i +: 8];
    end
  endtask

  // Response monitor
  resp_t mon_e;
  int    mon_due;
  always @(negedge clk) begin
    if (!rst && resp_valid) begin
      if (exp_q.size() == 0) fail_now("unexpected_resp_valid");
      else begin
        mon_e = exp_q.pop_front();
        mon_due = (mon_e.kind == 0) ? mon_e.accept + 1 :
                  (mon_e.kind == 1) ? last_mresp + 1 : mon_e.accept + TMO + 1;
        chk("resp_cycle", cyc, mon_due);
        chk("resp_err", {31'b0, resp_err}, {31'b0, mon_e.err});
        chk("resp_rdata", resp_rdata, mon_e.rdata);
      end
    end
  end

  // Memory responder
  bit   r_act = 1'b0;
  bit   r_done = 1'b0;
  int   r_wait = 0;
  mtx_t r_cur;
  always @(negedge clk) begin
    mem_resp = 1'b0;
    mem_rdata = $urandom;
    if (rst) begin
      r_act = 1'b0;
    end else if (mem_read || mem_write) begin
      if (r_act && r_done) begin fail_now("mem_req_held_after_resp"); r_act = 1'b0; end
      if (!r_act) begin
        if (mtx_q.size() == 0) fail_now("unexpected_mem_access");
        else begin
          r_cur = mtx_q.pop_front();
          r_act = 1'b1; r_done = 1'b0; r_wait = 0;
          chk("mem_write", {31'b0, mem_write}, {31'b0, r_cur.we});
          chk("mem_read", {31'b0, mem_read}, {31'b0, !r_cur.we});
          chk("mem_address", mem_address, r_cur.addr);
          chk("mem_byte_enable", {28'b0, mem_byte_enable}, {28'b0, r_cur.be});
          if (r_cur.we) chk("mem_wdata", mem_wdata, r_cur.wdata);
        end
      end else begin
        chk("mem_address_stable", mem_address, r_cur.addr);
        chk("mem_be_stable", {28'b0, mem_byte_enable}, {28'b0, r_cur.be});
        chk("req_ready_low_while_busy", {31'b0, req_ready}, 32'd0);
      end
      if (r_act) begin
        if (r_cur.delay == r_wait) begin
          mem_resp = 1'b1;
          last_mresp = cyc;
          r_done = 1'b1;
          if (r_cur.we) begin
            for (int b = 0; b < 4; b++)
              if (mem_byte_enable[b]) phys_mem[{mem_address[5:2], 2'(b)}] = mem_wdata[8*b +: 8];
          end else begin
            for (int b = 0; b < 4; b++) mem_rdata[8*b +: 8] = phys_mem[{mem_address[5:2], 2'(b)}];
          end
        end
        r_wait++;
      end
    end else begin
      if (r_act && !r_done && r_cur.delay >= 0) fail_now("mem_access_dropped");
      r_act = 1'b0;
      // Stray responses outside an access must be ignored by the DUT.
      if ($urandom_range(7) == 0) mem_resp = 1'b1;
    end
  end

  localparam logic [6:0] OTHERS[4] = '{7'b0010011, 7'b0110011, 7'b0110111, 7'b1100011};
  localparam logic [2:0] LD_F3[5]  = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5};

  initial begin
    logic [6:0]  op;
    logic [2:0]  f3;
    logic [31:0] a, w;
    int d, r;
    for (int i = 0; i < 64; i++) begin
      ref_mem[i] = 8'($urandom);
      phys_mem[i] = ref_mem[i];
    end
    rst = 1'b1; req_valid = 1'b0; req_opcode = '0; req_funct3 = '0; req_addr = '0; req_wdata = '0;
    repeat (3) @(negedge clk);
    chk("rst_req_ready", {31'b0, req_ready}, 32'd1);
    chk("rst_resp_valid", {31'b0, resp_valid}, 32'd0);
    chk("rst_resp_err", {31'b0, resp_err}, 32'd0);
    chk("rst_resp_rdata", resp_rdata, 32'd0);
    chk("rst_mem_read", {31'b0, mem_read}, 32'd0);
    chk("rst_mem_write", {31'b0, mem_write}, 32'd0);
    chk("rst_mem_address", mem_address, 32'd0);
    chk("rst_mem_wdata", mem_wdata, 32'd0);
    chk("rst_mem_byte_enable", {28'b0, mem_byte_enable}, 32'd0);
    rst = 1'b0;

    // Directed cases
    issue(OP_ST, 3'b000, 32'h0000_1003, 32'h0000_00A5, 2);   // sb, top lane
    drain();
    poke_word(32'h0000_2000, 32'h1234_80FF);
    issue(OP_LD, 3'b000, 32'h0000_2001, 32'h0, 1);           // lb -> FFFFFF80
    issue(OP_LD, 3'b100, 32'h0000_2001, 32'h0, 0);           // lbu -> 00000080
    issue(OP_LD, 3'b101, 32'h0000_2002, 32'h0, 3);           // lhu -> 00001234
    issue(OP_LD, 3'b010, 32'h0000_2000, 32'h0, 5);           // lw, 5 wait cycles
    issue(OP_LD, 3'b010, 32'h0000_3002, 32'h0, 2);           // misaligned lw
    issue(OP_ST, 3'b001, 32'h0000_3001, 32'h0000_BEEF, 1);   // misaligned sh
    issue(OP_LD, 3'b011, 32'h0000_2000, 32'h0, 0);           // illegal load funct3
    issue(OP_ST, 3'b011, 32'h0000_2000, 32'h0, 0);           // illegal store funct3
    issue(7'b0010011, 3'b000, 32'h0000_2000, 32'h0, 0);      // non-memory opcode
    issue(OP_LD, 3'b010, 32'h0000_2004, 32'h0, -1);          // timeout
    issue(OP_ST, 3'b010, 32'h0000_2008, 32'hCAFE_F00D, TMO - 1); // resp on terminal count
    issue(OP_LD, 3'b010, 32'h0000_2008, 32'h0, 0);
    drain();

    // Reset in the middle of an access
    issue(OP_LD, 3'b010, 32'h0000_0010, 32'h0, -1);
    repeat (3) @(negedge clk);
    chk("mem_read_before_rst", {31'b0, mem_read}, 32'd1);
    #1 rst = 1'b1;
    #1;
    chk("mem_read_in_rst", {31'b0, mem_read}, 32'd0);
    chk("req_ready_in_rst", {31'b0, req_ready}, 32'd1);
    exp_q.delete();
    mtx_q.delete();
    @(negedge clk);
    rst = 1'b0;
    repeat (12) @(negedge clk);
    issue(OP_LD, 3'b001, 32'h0000_2002, 32'h0, 1);
    drain();

    // Randomized traffic
    for (int k = 0; k < 150; k++) begin
      r = $urandom_range(9);
      if (r < 4)      op = OP_LD;
      else if (r < 8) op = OP_ST;
      else            op = OTHERS[$urandom_range(3)];
      if ($urandom_range(7) == 0)  f3 = 3'($urandom_range(7));
      else if (op == OP_ST)        f3 = 3'($urandom_range(2));
      else                         f3 = LD_F3[$urandom_range(4)];
      a = $urandom;
      w = $urandom;
      d = ($urandom_range(11) == 0) ? -1 : int'($urandom_range(TMO - 1));
      repeat ($urandom_range(2)) @(negedge clk);
      issue(op, f3, a, w, d);
    end
    drain();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
